// File: rtl/fp_mul.sv
// IEEE-754 binary32 multiplier: combinational decode/multiply/round, one output register.
// Define FPMUL_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to signed zero.
module fp_mul (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  control,
  output logic [31:0] result,
  output logic [4:0]  flags
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

`ifdef FPMUL_SUBNORMAL_EN
  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) begin
        n = 5'(23 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction
`endif

  // Returns {exponent, significand}; subnormals are left-aligned so bit 23 is always set.
  function automatic logic [34:0] unpack(input logic [31:0] v);
    logic [23:0] sig;
    logic [10:0] e;
`ifdef FPMUL_SUBNORMAL_EN
    logic [4:0]  lz;
    sig = {(v[30:23] != 8'd0), v[22:0]};
    e   = (v[30:23] == 8'd0) ? 11'd1 : {3'b000, v[30:23]};
    lz  = lzc24(sig);
    sig = sig << lz;
    e   = e - {6'd0, lz};
`else
    sig = {1'b1, v[22:0]};
    e   = {3'b000, v[30:23]};
`endif
    return {e, sig};
  endfunction

  logic               sign_s, a_nan_s, b_nan_s, a_snan_s, b_snan_s;
  logic               a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [34:0]        ua_s, ub_s;
  logic [47:0]        prod_s, norm_s, shifted_s;
  logic signed [10:0] exp_s;
  logic [10:0]        exp_base_s;
  logic [23:0]        sig_s;
  logic               tiny_s, lost_s, flush_s, guard_s, rbit_s, sticky_s;
  logic               inexact_s, round_up_s, overflow_s, uflow_s;
  logic [33:0]        rounded_s;
  logic [31:0]        result_d, result_q;
  logic [4:0]         flags_d, flags_q;
  logic               unused_ctrl_s;
`ifdef FPMUL_SUBNORMAL_EN
  logic [5:0]         shamt_s;
`endif

  assign unused_ctrl_s = ^control[4:2];

  // Operand classification
  always_comb begin
    sign_s   = a[31] ^ b[31];
    a_nan_s  = (a[30:23] == 8'hFF) & (a[22:0] != 23'd0);
    b_nan_s  = (b[30:23] == 8'hFF) & (b[22:0] != 23'd0);
    a_snan_s = a_nan_s & ~a[22];
    b_snan_s = b_nan_s & ~b[22];
    a_inf_s  = (a[30:23] == 8'hFF) & (a[22:0] == 23'd0);
    b_inf_s  = (b[30:23] == 8'hFF) & (b[22:0] == 23'd0);
`ifdef FPMUL_SUBNORMAL_EN
    a_zero_s = (a[30:0] == 31'd0);
    b_zero_s = (b[30:0] == 31'd0);
`else
    a_zero_s = (a[30:23] == 8'd0);
    b_zero_s = (b[30:23] == 8'd0);
`endif
  end

  // Multiply, normalise, denormalise if tiny, then round
  always_comb begin
    ua_s   = unpack(a);
    ub_s   = unpack(b);
    prod_s = {24'd0, ua_s[23:0]} * {24'd0, ub_s[23:0]};
    norm_s = prod_s[47] ? prod_s : {prod_s[46:0], 1'b0};
    exp_s  = $signed(ua_s[34:24]) + $signed(ub_s[34:24]) - 11'sd127
             + $signed({10'd0, prod_s[47]});
    tiny_s = (exp_s < 11'sd1);
`ifdef FPMUL_SUBNORMAL_EN
    if (tiny_s) begin
      shamt_s    = (exp_s < -11'sd47) ? 6'd48 : 6'(11'sd1 - exp_s);
      exp_base_s = 11'd0;
    end else begin
      shamt_s    = 6'd0;
      exp_base_s = exp_s - 11'sd1;
    end
    shifted_s = norm_s >> shamt_s;
    lost_s    = |(norm_s & ((48'd1 << shamt_s) - 48'd1));
    flush_s   = 1'b0;
`else
    exp_base_s = exp_s - 11'sd1;
    shifted_s  = norm_s;
    lost_s     = 1'b0;
    flush_s    = tiny_s;
`endif
    sig_s     = shifted_s[47:24];
    guard_s   = shifted_s[23];
    rbit_s    = shifted_s[22];
    sticky_s  = (|shifted_s[21:0]) | lost_s;
    inexact_s = guard_s | rbit_s | sticky_s;
    case (control[1:0])
      2'b00:   round_up_s = guard_s & (rbit_s | sticky_s | sig_s[0]);
      2'b01:   round_up_s = 1'b0;
      2'b10:   round_up_s = ~sign_s & inexact_s;
      2'b11:   round_up_s = sign_s & inexact_s;
      default: round_up_s = 1'b0;
    endcase
    // The hidden bit adds the missing 1 back into the exponent field; a rounding carry renormalises.
    rounded_s  = {exp_base_s, 23'd0} + {10'd0, sig_s} + {33'd0, round_up_s};
    overflow_s = ~tiny_s & (rounded_s[33:23] >= 11'd255);
    uflow_s    = tiny_s & inexact_s;
  end

  // Special-case priority and overflow saturation
  always_comb begin
    result_d = {sign_s, rounded_s[30:0]};
    flags_d  = {3'b000, uflow_s, inexact_s};
    if (a_nan_s | b_nan_s) begin
      result_d = QNAN;
      flags_d  = {(a_snan_s | b_snan_s), 4'b0000};
    end else if ((a_inf_s & b_zero_s) | (b_inf_s & a_zero_s)) begin
      result_d = QNAN;
      flags_d  = 5'b10000;
    end else if (a_inf_s | b_inf_s) begin
      result_d = {sign_s, 31'h7F800000};
      flags_d  = 5'b00000;
    end else if (a_zero_s | b_zero_s) begin
      result_d = {sign_s, 31'd0};
      flags_d  = 5'b00000;
    end else if (flush_s) begin
      result_d = {sign_s, 31'd0};
      flags_d  = 5'b00011;
    end else if (overflow_s) begin
      flags_d = 5'b00101;
      case (control[1:0])
        2'b00:   result_d = {sign_s, 31'h7F800000};
        2'b01:   result_d = {sign_s, 31'h7F7FFFFF};
        2'b10:   result_d = {sign_s, sign_s ? 31'h7F7FFFFF : 31'h7F800000};
        2'b11:   result_d = {sign_s, sign_s ? 31'h7F800000 : 31'h7F7FFFFF};
        default: result_d = {sign_s, 31'h7F800000};
      endcase
    end else begin
      result_d = {sign_s, rounded_s[30:0]};
      flags_d  = {3'b000, uflow_s, inexact_s};
    end
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= 32'd0;
      flags_q  <= 5'd0;
    end else if (clk_enable) begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end else begin
      result_q <= result_q;
      flags_q  <= flags_q;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_fp_mul.sv
// Directed bench for fp_mul: value-level reference model plus hand-computed literal checks.
module tb_fp_mul;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  control = 5'd0;
  logic [31:0] result;
  logic [4:0]  flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_res = 32'd0;
  logic [4:0]  exp_flg = 5'd0;

  fp_mul dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .a(a), .b(b), .control(control),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  // Exact integer product, rounded by comparing the discarded remainder against one half.
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic [1:0] mode);
    int     ex, ey, be, k;
    logic   s, xn, yn, xs, ys, xi, yi, xz, yz, up, to_inf;
    longint mx, my, q, rem, half;
    ex = {24'd0, x[30:23]};
    ey = {24'd0, y[30:23]};
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn) return {(xs || ys) ? 5'b10000 : 5'b00000, 32'h7FC00000};
    if ((xi && yz) || (yi && xz)) return {5'b10000, 32'h7FC00000};
    if (xi || yi) return {5'b00000, s, 31'h7F800000};
    if (xz || yz) return {5'b00000, s, 31'd0};
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    q  = mx * my;
    k  = 0;
    while ((q >> k) >= 64'd16777216) k++;
    rem  = q & ((64'd1 << k) - 64'd1);
    half = (k > 0) ? (64'd1 << (k - 1)) : 64'd0;
    q    = q >> k;
    be   = ex + ey - 150 + k;
    if (be <= 0) return {5'b00011, s, 31'd0};
    case (mode)
      2'd0:    up = (rem > half) || ((rem == half) && (rem != 0) && q[0]);
      2'd1:    up = 1'b0;
      2'd2:    up = !s && (rem != 0);
      default: up = s && (rem != 0);
    endcase
    q = q + (up ? 64'd1 : 64'd0);
    if (q == 64'd16777216) begin
      q  = q >> 1;
      be = be + 1;
    end
    if (be >= 255) begin
      to_inf = (mode == 2'd0) || ((mode == 2'd2) && !s) || ((mode == 2'd3) && s);
      return {5'b00101, s, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
    end
    return {4'b0000, (rem != 0), s, be[7:0], q[22:0]};
  endfunction

  // Expected output register
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_res <= 32'd0;
      exp_flg <= 5'd0;
    end else if (clk_enable) begin
      {exp_flg, exp_res} <= model(a, b, control[1:0]);
    end
  end

  // Compare against the model on every falling edge
  always @(negedge clk) begin
    n_cmp++;
    if (result !== exp_res || flags !== exp_flg) begin
      n_bad++;
      $display("FAIL model @%0t: a=%h b=%h ctl=%b got %h/%b want %h/%b",
               $time, a, b, control, result, flags, exp_res, exp_flg);
    end
  end

  task automatic check(input string name, input logic [31:0] er, input logic [4:0] ef);
    n_cmp++;
    if (result !== er || flags !== ef) begin
      n_bad++;
      $display("FAIL %s: got %h/%b want %h/%b", name, result, flags, er, ef);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] x, input logic [31:0] y,
                     input logic [1:0] m, input logic [31:0] er, input logic [4:0] ef);
    logic [36:0] r;
    r = model(x, y, m);
    n_cmp++;
    if (r[31:0] !== er || r[36:32] !== ef) begin
      n_bad++;
      $display("FAIL %s: model %h/%b want %h/%b", name, r[31:0], r[36:32], er, ef);
    end
  endtask

  task automatic step(input logic [31:0] x, input logic [31:0] y, input logic [4:0] c,
                      input logic ce);
    a = x;
    b = y;
    control = c;
    clk_enable = ce;
    @(posedge clk);
    #2;
  endtask

  initial begin
    pin("pin_rne", 32'h43A03333, 32'h41633333, 2'd0, 32'h458E2D70, 5'b00001);
    pin("pin_up",  32'h3F800001, 32'h3F800001, 2'd2, 32'h3F800003, 5'b00001);
    pin("pin_ovf", 32'hFF000000, 32'h7F000000, 2'd2, 32'hFF7FFFFF, 5'b00101);

    #2;
    check("reset_state", 32'd0, 5'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    step(32'h43A03333, 32'h41633333, 5'd0, 1'b1);
    check("first_capture", 32'h458E2D70, 5'b00001);
    step(32'h3F800000, 32'h40000000, 5'd0, 1'b1);
    check("one_times_two", 32'h40000000, 5'b00000);
    step(32'h40400000, 32'h40400000, 5'd0, 1'b0);
    step(32'h7F800000, 32'h00000000, 5'd0, 1'b0);
    check("hold", 32'h40000000, 5'b00000);
    step(32'h7F800000, 32'h00000000, 5'd0, 1'b1);
    check("inf_x_zero", 32'h7FC00000, 5'b10000);
    step(32'hFF800000, 32'h40000000, 5'd0, 1'b1);
    check("neg_inf", 32'hFF800000, 5'b00000);
    step(32'h7F000000, 32'h7F000000, 5'd0, 1'b1);
    check("ovf_rne", 32'h7F800000, 5'b00101);
    step(32'h7F000000, 32'h7F000000, 5'd1, 1'b1);
    check("ovf_rtz", 32'h7F7FFFFF, 5'b00101);
    step(32'hFF000000, 32'h7F000000, 5'd3, 1'b1);
    check("ovf_ninf_neg", 32'hFF800000, 5'b00101);
    step(32'h1F800000, 32'h1F800000, 5'd0, 1'b1);
    check("tiny", 32'h00000000, 5'b00011);
    step(32'h7F800001, 32'h3F800000, 5'd0, 1'b1);
    check("snan", 32'h7FC00000, 5'b10000);
    step(32'h7FC00000, 32'h00000000, 5'd0, 1'b1);
    check("qnan", 32'h7FC00000, 5'b00000);
    step(32'h80000000, 32'h40000000, 5'd0, 1'b1);
    check("neg_zero", 32'h80000000, 5'b00000);
    step(32'h3F800001, 32'h3F800001, 5'd0, 1'b1);
    check("ulp_rne", 32'h3F800002, 5'b00001);
    step(32'h3F800001, 32'h3F800001, 5'd2, 1'b1);
    check("ulp_pinf", 32'h3F800003, 5'b00001);
    step(32'hBF800001, 32'h3F800001, 5'd3, 1'b1);
    check("ulp_ninf_neg", 32'hBF800003, 5'b00001);
    step(32'hBF800001, 32'h3F800001, 5'd2, 1'b1);
    check("ulp_pinf_neg", 32'hBF800002, 5'b00001);
    step(32'h3F800001, 32'h40400000, 5'd0, 1'b1);
    check("tie_odd", 32'h40400002, 5'b00001);
    step(32'h43A03333, 32'h41633333, 5'b11100, 1'b1);
    check("reserved_bits", 32'h458E2D70, 5'b00001);

    // Extra directed patterns checked only by the model
    step(32'hC1200000, 32'h3DCCCCCD, 5'd1, 1'b1);
    step(32'h00400000, 32'h40000000, 5'd0, 1'b1);
    step(32'h7F800000, 32'hFF800000, 5'd0, 1'b1);
    step(32'h20000000, 32'h1F000000, 5'd2, 1'b1);
    step(32'h3FFFFFFF, 32'h3FFFFFFF, 5'd2, 1'b1);
    for (int i = 0; i < 64; i++) begin
      step($urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'b1);
    end

    step(32'h40000000, 32'h40000000, 5'd0, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("async_reset", 32'd0, 5'd0);
    step(32'h40000000, 32'h40400000, 5'd0, 1'b1);
    check("reset_held", 32'd0, 5'd0);
    reset = 1'b1;
    step(32'h3F800000, 32'h40400000, 5'd0, 1'b1);
    check("after_reset", 32'h40400000, 5'b00000);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
